mips_processor: RTL and testbench

MIPS_PROCESSOR -- requirements
Module: mips_processor

---
 rtl/mips_processor_pkg.sv | 35 +++
 rtl/mips_processor_datapath.sv | 60 ++++++
 rtl/mips_processor.sv | 56 +++++
 tb/tb_mips_processor.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mips_processor_pkg.sv
// mips_processor_pkg: opcodes, funct codes, ALU/FSM enums and the control bundle.
package mips_processor_pkg;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_J = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;
  typedef enum logic [1:0] {SRC_REG, SRC_IMM, SRC_OFF} src_b_t;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;
  typedef struct packed {
    logic    ir_write;
    logic    pc_inc;
    logic    pc_branch;
    logic    pc_jump;
    logic    ab_load;
    logic    alu_load;
    logic    src_a_pc;
    src_b_t  src_b;
    alu_op_t alu;
    logic    mdr_load;
    logic    iord;
    logic    reg_write;
    logic    mem_to_reg;
    logic    reg_dst;
  } ctrl_t;
  function automatic alu_op_t funct_to_alu(input logic [5:0] f);
    return f == FN_SUB ? ALU_SUB : f == FN_AND ? ALU_AND : f == FN_OR ? ALU_OR :
           f == FN_SLT ? ALU_SLT : ALU_ADD;
  endfunction
  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    return op == ALU_SUB ? a - b : op == ALU_AND ? a & b : op == ALU_OR ? a | b :
           op == ALU_SLT ? {31'd0, $signed(a) < $signed(b)} : a + b;
  endfunction
endpackage

// File: rtl/mips_processor_datapath.sv
// mips_datapath: PC, IR, MDR, A/B, ALUOut, register file and ALU of the multicycle core.
module mips_datapath
  import mips_processor_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memdata,
  input  ctrl_t       ctrl,
  output logic [31:0] addr,
  output logic [31:0] writedata,
  output logic [5:0]  op,
  output logic [5:0]  funct
);
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, alu_out_q, alu_out_d, mdr_q, mdr_d;
  logic [31:0] rf_q [32];
  logic [31:0] pcout, instruct, Ain, Bin, wrData, imm, src_a, src_b;
  logic [4:0]  wrAddr;
  assign pcout     = pc_q;
  assign instruct  = ir_q;
  assign Ain       = a_q;
  assign Bin       = b_q;
  assign op        = instruct[31:26];
  assign funct     = instruct[5:0];
  assign writedata = Bin;
  assign addr      = ctrl.iord ? alu_out_q : pcout;
  assign wrAddr    = ctrl.reg_dst ? instruct[15:11] : instruct[20:16];
  assign wrData    = ctrl.mem_to_reg ? mdr_q : alu_out_q;
  always_comb begin
    imm       = {{16{instruct[15]}}, instruct[15:0]};
    src_a     = ctrl.src_a_pc ? pcout : Ain;
    src_b     = ctrl.src_b == SRC_REG ? Bin : ctrl.src_b == SRC_IMM ? imm : imm << 2;
    pc_d      = ctrl.pc_inc ? pcout + 32'd4 :
                ctrl.pc_jump ? {pcout[31:28], instruct[25:0], 2'b00} :
                (ctrl.pc_branch && Ain == Bin) ? alu_out_q : pcout;
    ir_d      = ctrl.ir_write ? memdata : ir_q;
    a_d       = ctrl.ab_load ? rf_q[instruct[25:21]] : a_q;
    b_d       = ctrl.ab_load ? rf_q[instruct[20:16]] : b_q;
    alu_out_d = ctrl.alu_load ? alu(ctrl.alu, src_a, src_b) : alu_out_q;
    mdr_d     = ctrl.mdr_load ? memdata : mdr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      if (ctrl.reg_write && wrAddr != 5'd0) rf_q[wrAddr] <= wrData;
    end
  end
endmodule

// File: rtl/mips_processor.sv
// mips_processor: multicycle MIPS-32 core; Moore controller FSM driving mips_datapath.
module mips_processor
  import mips_processor_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memdata,
  output logic [31:0] addr,
  output logic        memread,
  output logic        memwrite,
  output logic [31:0] writedata
);
  state_t     state_q, state_d;
  ctrl_t      ctrl;
  logic       regwrite;
  logic [5:0] op, funct;
  assign memread  = state_q == FETCH || state_q == MEMRD;
  assign memwrite = state_q == MEMWR;
  assign regwrite = state_q == MEMWB || state_q == ALUWB || state_q == ADDIWB;
  always_comb begin
    ctrl            = '0;
    ctrl.ir_write   = state_q == FETCH;
    ctrl.pc_inc     = state_q == FETCH;
    ctrl.ab_load    = state_q == DECODE;
    ctrl.src_a_pc   = state_q == DECODE;
    ctrl.src_b      = state_q == DECODE ? SRC_OFF :
                      (state_q == MEMADR || state_q == ADDIEX) ? SRC_IMM : SRC_REG;
    ctrl.alu        = state_q == EXECUTE ? funct_to_alu(funct) : ALU_ADD;
    ctrl.alu_load   = state_q == DECODE || state_q == MEMADR || state_q == ADDIEX || state_q == EXECUTE;
    ctrl.mdr_load   = state_q == MEMRD;
    ctrl.iord       = state_q == MEMRD || state_q == MEMWR;
    ctrl.reg_write  = regwrite;
    ctrl.mem_to_reg = state_q == MEMWB;
    ctrl.reg_dst    = state_q == ALUWB;
    ctrl.pc_branch  = state_q == BRANCH;
    ctrl.pc_jump    = state_q == JUMP;
  end
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE:  state_d = (op == OP_LW || op == OP_SW) ? MEMADR : op == OP_RTYPE ? EXECUTE :
                         op == OP_BEQ ? BRANCH : op == OP_ADDI ? ADDIEX : op == OP_J ? JUMP : FETCH;
      MEMADR:  state_d = op == OP_LW ? MEMRD : MEMWR;
      MEMRD:   state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk) state_q <= reset ? FETCH : state_d;
  mips_datapath datapath (
    .clk(clk), .reset(reset), .memdata(memdata), .ctrl(ctrl),
    .addr(addr), .writedata(writedata), .op(op), .funct(funct)
  );
endmodule

// File: tb/tb_mips_processor.sv
// tb_mips_processor: program table with a write scoreboard, plus reset/branch/jump sequences.
module tb_mips_processor;
  logic        clk = 0, reset = 1;
  logic [31:0] memdata = '0, addr, writedata;
  logic        memread, memwrite;
  int          checks = 0, failures = 0;
  logic [31:0] mem [64];
  typedef struct {logic st; logic [31:0] a, d;} ev_t;
  ev_t q[$];
  typedef struct {logic [31:0] a, instr; int n; int kind; logic [31:0] wa, wd, pc;} vec_t;
  vec_t tbl[19];

  mips_processor dut (.clk(clk), .reset(reset), .memdata(memdata), .addr(addr),
                      .memread(memread), .memwrite(memwrite), .writedata(writedata));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    ev_t e;
    memdata = memread ? mem[addr[7:2]] : 32'h0;
    chk("mem_excl", {31'd0, memread & memwrite}, 32'd0);
    if (dut.regwrite || memwrite) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write actual=%h/%h expected=none",
                 memwrite ? addr : {27'd0, dut.datapath.wrAddr}, memwrite ? writedata : dut.datapath.wrData);
      end else begin
        e = q.pop_front();
        chk("ev_is_store", {31'd0, memwrite}, {31'd0, e.st});
        chk("ev_addr", memwrite ? addr : {27'd0, dut.datapath.wrAddr}, e.a);
        chk("ev_data", memwrite ? writedata : dut.datapath.wrData, e.d);
      end
      if (memwrite) mem[addr[7:2]] = writedata;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1; memdata = '0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    tbl[0]  = '{32'h00, 32'h20020005, 4, 1, 32'd2, 32'd5, 32'h04};
    tbl[1]  = '{32'h04, 32'h20030007, 4, 1, 32'd3, 32'd7, 32'h08};
    tbl[2]  = '{32'h08, 32'h00432020, 4, 1, 32'd4, 32'h0C, 32'h0C};
    tbl[3]  = '{32'h0C, 32'h00622022, 4, 1, 32'd4, 32'd2, 32'h10};
    tbl[4]  = '{32'h10, 32'h00432024, 4, 1, 32'd4, 32'd5, 32'h14};
    tbl[5]  = '{32'h14, 32'h00432025, 4, 1, 32'd4, 32'd7, 32'h18};
    tbl[6]  = '{32'h18, 32'h0062202A, 4, 1, 32'd4, 32'd0, 32'h1C};
    tbl[7]  = '{32'h1C, 32'h0043202A, 4, 1, 32'd4, 32'd1, 32'h20};
    tbl[8]  = '{32'h20, 32'h2005FFFF, 4, 1, 32'd5, 32'hFFFFFFFF, 32'h24};
    tbl[9]  = '{32'h24, 32'h00A2202A, 4, 1, 32'd4, 32'd1, 32'h28};
    tbl[10] = '{32'h28, 32'h00A22020, 4, 1, 32'd4, 32'd4, 32'h2C};
    tbl[11] = '{32'h2C, 32'hAC020008, 4, 2, 32'd8, 32'd5, 32'h30};
    tbl[12] = '{32'h30, 32'h8C030008, 5, 1, 32'd3, 32'd5, 32'h34};
    tbl[13] = '{32'h34, 32'h20000009, 4, 1, 32'd0, 32'd9, 32'h38};
    tbl[14] = '{32'h38, 32'h00022020, 4, 1, 32'd4, 32'd5, 32'h3C};
    tbl[15] = '{32'h3C, 32'h10450003, 3, 0, 32'd0, 32'd0, 32'h40};
    tbl[16] = '{32'h40, 32'h08000014, 3, 0, 32'd0, 32'd0, 32'h50};
    tbl[17] = '{32'h50, 32'hFC000000, 2, 0, 32'd0, 32'd0, 32'h54};
    tbl[18] = '{32'h54, 32'h10420002, 3, 0, 32'd0, 32'd0, 32'h60};
    foreach (tbl[i]) mem[tbl[i].a[7:2]] = tbl[i].instr;

    do_reset();
    chk("rst_addr", addr, 32'h0);
    chk("rst_memread", {31'd0, memread}, 32'd1);
    chk("rst_memwrite", {31'd0, memwrite}, 32'd0);
    chk("rst_regwrite", {31'd0, dut.regwrite}, 32'd0);
    chk("rst_writedata", writedata, 32'h0);
    chk("rst_pcout", dut.datapath.pcout, 32'h0);
    cyc();
    chk("fetch_pcout", dut.datapath.pcout, 32'h4);
    chk("fetch_instruct", dut.datapath.instruct, 32'h20020005);
    do_reset();
    chk("abort_pcout", dut.datapath.pcout, 32'h0);

    foreach (tbl[i]) begin
      chk($sformatf("v%0d_fetch_addr", i), addr, tbl[i].a);
      if (tbl[i].kind != 0) q.push_back('{tbl[i].kind == 2, tbl[i].wa, tbl[i].wd});
      repeat (tbl[i].n) cyc();
      chk($sformatf("v%0d_pending", i), q.size(), 32'd0);
      q.delete();
      chk($sformatf("v%0d_pc", i), dut.datapath.pcout, tbl[i].pc);
      if (i == 2) begin
        chk("add_Ain", dut.datapath.Ain, 32'd5);
        chk("add_Bin", dut.datapath.Bin, 32'd7);
      end
    end

    do_reset();
    mem[0] = 32'h08000004;
    mem[4] = 32'h1042FFFF;
    repeat (3) cyc();
    chk("jump_pc", dut.datapath.pcout, 32'h10);
    repeat (3) cyc();
    chk("beq_self_pc", dut.datapath.pcout, 32'h10);
    mem[4] = 32'h00432020;
    repeat (2) cyc();
    reset = 1;
    @(posedge clk); #1;
    chk("midrst_regwrite", {31'd0, dut.regwrite}, 32'd0);
    chk("midrst_pcout", dut.datapath.pcout, 32'h0);
    chk("midrst_addr", addr, 32'h0);
    reset = 0;
    cyc();
    chk("midrst_regwrite2", {31'd0, dut.regwrite}, 32'd0);
    chk("midrst_pending", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
